// File: rtl/cmd_frame_decoder_pkg.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder_pkg : opcode constants and FSM state encoding | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cmd_frame_decoder_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU     = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    ALU_A   = 3'd4,
    ALU_B   = 3'd5,
    ALU_FUN = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_frame_decoder_timer.sv
// ---------------------------------------------------------------------------
// frame_timer : inter-byte watchdog for cmd_frame_decoder | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the edge where the count would reach TIMEOUT-1; a byte in the same cycle wins.
  assign expire = run && !clear && (count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder : byte-stream command framer -> RF / ALU strobes | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmd_frame_decoder
  import cmd_frame_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  alu_en,
  output logic                  frame_err,
  output logic                  busy
);

  state_t state;
  logic   expire;

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .RST    (RST),
    .clear  (rx_valid || (state == IDLE)),
    .run    (state != IDLE),
    .expire (expire)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_op_a   <= '0;
      alu_op_b   <= '0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rf_wr_en  <= 1'b0;
      rf_rd_en  <= 1'b0;
      alu_en    <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            case (rx_data)
              DATA_WIDTH'(CMD_WR):      state <= WR_ADDR;
              DATA_WIDTH'(CMD_RD):      state <= RD_ADDR;
              DATA_WIDTH'(CMD_ALU):     state <= ALU_A;
              DATA_WIDTH'(CMD_ALU_NOP): state <= ALU_FUN;
              default:                  frame_err <= 1'b1;
            endcase
          end
          WR_ADDR: begin
            rf_addr <= rx_data[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
          WR_DATA: begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= IDLE;
          end
          RD_ADDR: begin
            rf_addr  <= rx_data[ADDR_WIDTH-1:0];
            rf_rd_en <= 1'b1;
            state    <= IDLE;
          end
          ALU_A: begin
            alu_op_a <= rx_data;
            state    <= ALU_B;
          end
          ALU_B: begin
            alu_op_b <= rx_data;
            state    <= ALU_FUN;
          end
          ALU_FUN: begin
            alu_fun <= rx_data[FUN_WIDTH-1:0];
            alu_en  <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (expire) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_decoder : directed self-checking bench | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmd_frame_decoder;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] alu_op_a;
  logic [7:0] alu_op_b;
  logic [3:0] alu_fun;
  logic       alu_en;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cmd_frame_decoder #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .FUN_WIDTH  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_fun    (alu_fun),
    .alu_en     (alu_en),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Byte driven at a falling edge, sampled on the next rising edge; returns one
  // falling edge later, where the resulting strobe (if any) is visible.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [3:0] strobes();
    return {rf_wr_en, rf_rd_en, alu_en, frame_err};
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", strobes());
    end
    vectors++;
    if ({rf_addr, rf_wr_data, alu_op_a, alu_op_b, alu_fun} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {rf_addr, rf_wr_data, alu_op_a, alu_op_b, alu_fun});
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    send(8'hAA);
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy: got %b want 1", busy);
    end
    send(8'h05);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL wr_early_strobe: got %b want 0000", strobes());
    end
    send(8'h3C);
    vectors++;
    if (strobes() !== 4'b1000 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
      errors++; $display("FAIL wr_strobe: strobes %b addr %h data %h want 1000 5 3c", strobes(), rf_addr, rf_wr_data);
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000 || rf_wr_data !== 8'h3C || busy !== 1'b0) begin
      errors++; $display("FAIL wr_after: strobes %b data %h busy %b want 0000 3c 0", strobes(), rf_wr_data, busy);
    end
  endtask

  task automatic test_back_to_back();
    send(8'hBB);
    send(8'h07);
    vectors++;
    if (strobes() !== 4'b0100 || rf_addr !== 4'h7) begin
      errors++; $display("FAIL b2b_rd: strobes %b addr %h want 0100 7", strobes(), rf_addr);
    end
    send(8'hCC);
    send(8'h12);
    send(8'h34);
    send(8'h01);
    vectors++;
    if (strobes() !== 4'b0010 || alu_op_a !== 8'h12 || alu_op_b !== 8'h34 || alu_fun !== 4'h1) begin
      errors++; $display("FAIL b2b_alu: strobes %b a %h b %h fun %h want 0010 12 34 1", strobes(), alu_op_a, alu_op_b, alu_fun);
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL b2b_after: got %b want 0000", strobes());
    end
  endtask

  task automatic test_alu_nop();
    send(8'hDD);
    send(8'hF2);
    vectors++;
    if (strobes() !== 4'b0010 || alu_op_a !== 8'h12 || alu_op_b !== 8'h34 || alu_fun !== 4'h2) begin
      errors++; $display("FAIL alu_nop: strobes %b a %h b %h fun %h want 0010 12 34 2", strobes(), alu_op_a, alu_op_b, alu_fun);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_opcode();
    send(8'h55);
    vectors++;
    if (strobes() !== 4'b0001 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_op: strobes %b busy %b want 0001 0", strobes(), busy);
    end
    send(8'hAA);
    vectors++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL bad_op_clear: got %b want 0", frame_err);
    end
    send(8'h01);
    send(8'hFF);
    vectors++;
    if (strobes() !== 4'b1000 || rf_addr !== 4'h1 || rf_wr_data !== 8'hFF) begin
      errors++; $display("FAIL bad_op_recover: strobes %b addr %h data %h want 1000 1 ff", strobes(), rf_addr, rf_wr_data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    send(8'hAA);
    send(8'h03);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      vectors++;
      if (frame_err !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL timeout_wait[%0d]: err %b busy %b want 0 1", k, frame_err, busy);
      end
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0001 || busy !== 1'b0 || rf_addr !== 4'h3) begin
      errors++; $display("FAIL timeout_err: strobes %b busy %b addr %h want 0001 0 3", strobes(), busy, rf_addr);
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL timeout_after: got %b want 0000", strobes());
    end
  endtask

  task automatic test_byte_at_expiry();
    send(8'hAA);
    repeat (14) @(negedge clk);
    send(8'h04);
    vectors++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL expiry_race: err %b busy %b want 0 1", frame_err, busy);
    end
    send(8'h77);
    vectors++;
    if (strobes() !== 4'b1000 || rf_addr !== 4'h4 || rf_wr_data !== 8'h77) begin
      errors++; $display("FAIL expiry_race_wr: strobes %b addr %h data %h want 1000 4 77", strobes(), rf_addr, rf_wr_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    send(8'hAA);
    #2 RST = 1'b0;
    #1;
    vectors++;
    if (strobes() !== 4'b0000 || busy !== 1'b0 ||
        {rf_addr, rf_wr_data, alu_op_a, alu_op_b, alu_fun} !== 32'h0) begin
      errors++; $display("FAIL midframe_reset: strobes %b busy %b data %h want 0000 0 0",
                         strobes(), busy, {rf_addr, rf_wr_data, alu_op_a, alu_op_b, alu_fun});
    end
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    send(8'hAA);
    send(8'h02);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL midframe_no_stray: got %b want 0000", strobes());
    end
    send(8'h11);
    vectors++;
    if (strobes() !== 4'b1000 || rf_addr !== 4'h2 || rf_wr_data !== 8'h11) begin
      errors++; $display("FAIL midframe_wr: strobes %b addr %h data %h want 1000 2 11", strobes(), rf_addr, rf_wr_data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_alu_nop();
    test_bad_opcode();
    test_timeout();
    test_byte_at_expiry();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
